// File: rtl/mem_arbiter.sv
// Arbiter that shares one word-wide memory between a read-only fetch port and a
// read/write data port. Read bursts are split into word beats; data has priority.
//
// state | meaning
// IDLE  | no transfer; grants decided combinationally when memory is not busy
// XFER  | issuing beats of the latched request until the last beat is accepted
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic [1:0]  i_access_size,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_in,
    input  logic [1:0]  d_access_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [1:0]  m_access_size,
    output logic        m_rw,
    output logic        m_enable,
    input  logic        m_busy,
    input  logic [31:0] m_data_out
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;        // 1 = data port owns the transfer
    logic           rw_q, rw_d;
    logic [31:0]    base_q, base_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     last_q, last_d;
    logic [3:0]     beat_q, beat_d;
    logic           rd_flag_q, rd_flag_d;
    logic           rd_owner_q, rd_owner_d;
    logic [SW-1:0]  starve_q, starve_d;

    logic           gnt_data;
    logic           gnt_fetch;

    function automatic logic [3:0] last_beat(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            2'b00:   n = 4'd0;
            2'b01:   n = 4'd3;
            2'b10:   n = 4'd7;
            default: n = 4'd15;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        beat_d     = beat_q;
        rd_flag_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        gnt_data   = 1'b0;
        gnt_fetch  = 1'b0;
        m_enable   = 1'b0;
        m_address  = 32'd0;
        m_data_in  = 32'd0;
        m_rw       = 1'b1;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so they must be suppressed while reset is held.
                if (reset_n && !m_busy) begin
                    if (d_req && (!i_req || (starve_q < LIMIT))) begin
                        gnt_data = 1'b1;
                    end else if (i_req) begin
                        gnt_fetch = 1'b1;
                    end
                end
                if (gnt_data) begin
                    state_d = XFER;
                    owner_d = 1'b1;
                    rw_d    = d_rw;
                    base_d  = d_address;
                    wdata_d = d_data_in;
                    last_d  = d_rw ? last_beat(d_access_size) : 4'd0;
                    beat_d  = 4'd0;
                end else if (gnt_fetch) begin
                    state_d = XFER;
                    owner_d = 1'b0;
                    rw_d    = 1'b1;
                    base_d  = i_address;
                    wdata_d = 32'd0;
                    last_d  = last_beat(i_access_size);
                    beat_d  = 4'd0;
                end
            end
            XFER: begin
                m_enable  = 1'b1;
                m_address = base_q + {26'd0, beat_q, 2'b00};
                m_rw      = rw_q;
                m_data_in = wdata_q;
                if (!m_busy) begin
                    rd_flag_d  = rw_q;
                    rd_owner_d = owner_q;
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts data wins against a waiting fetch; any fetch grant or idle fetch port resets it.
        if (!i_req || gnt_fetch) begin
            starve_d = '0;
        end else if (gnt_data && (starve_q < LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rw_q       <= 1'b1;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            last_q     <= 4'd0;
            beat_q     <= 4'd0;
            rd_flag_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            rd_flag_q  <= rd_flag_d;
            rd_owner_q <= rd_owner_d;
            starve_q   <= starve_d;
        end
    end

    assign i_gnt         = gnt_fetch;
    assign d_gnt         = gnt_data;
    assign i_rvalid      = rd_flag_q & ~rd_owner_q;
    assign d_rvalid      = rd_flag_q & rd_owner_q;
    assign i_rdata       = i_rvalid ? m_data_out : 32'd0;
    assign d_rdata       = d_rvalid ? m_data_out : 32'd0;
    assign m_access_size = 2'b00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected read words, a
// negedge monitor pops and compares whenever either rvalid is asserted.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_address;
    logic [1:0]  i_access_size;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic [1:0]  d_access_size;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] m_address;
    logic [31:0] m_data_in;
    logic [1:0]  m_access_size;
    logic        m_rw;
    logic        m_enable;
    logic        m_busy;
    logic [31:0] m_data_out;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_req         (i_req),
        .i_address     (i_address),
        .i_access_size (i_access_size),
        .i_gnt         (i_gnt),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .d_req         (d_req),
        .d_rw          (d_rw),
        .d_address     (d_address),
        .d_data_in     (d_data_in),
        .d_access_size (d_access_size),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .m_address     (m_address),
        .m_data_in     (m_data_in),
        .m_access_size (m_access_size),
        .m_rw          (m_rw),
        .m_enable      (m_enable),
        .m_busy        (m_busy),
        .m_data_out    (m_data_out)
    );

    typedef struct packed {
        logic        port;   // 1 = data port
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [64:0] alog[$];    // {m_rw, m_address, m_data_in} per enabled cycle
    logic        glog[$];    // grant order, 1 = data
    exp_t        mon_e;
    logic [31:0] mem [1024];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] <= 32'hA000_0000 + k;
        mem[0] <= 32'h8FBE_0010;
        m_data_out <= 32'd0;
    end

    always @(posedge clock) begin
        if (m_enable && !m_busy) begin
            if (m_rw) m_data_out <= mem[m_address[11:2]];
            else      mem[m_address[11:2]] <= m_data_in;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [31:0] data);
        sb.push_back({port, data});
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (m_enable) alog.push_back({m_rw, m_address, m_data_in});
            if (i_gnt) glog.push_back(1'b0);
            if (d_gnt) glog.push_back(1'b1);
            if (i_rvalid || d_rvalid) begin
                if (i_rvalid && d_rvalid) chk("rvalid_both", 2'b11, 2'b01);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got i=%0b d=%0b expected none", i_rvalid, d_rvalid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rvalid_port", {i_rvalid, d_rvalid}, {~mon_e.port, mon_e.port});
                    chk("rdata", d_rvalid ? d_rdata : i_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic issue(input logic port, input logic rw, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wd);
        bit got = 0;
        if (port) begin
            d_req = 1'b1; d_rw = rw; d_address = addr; d_access_size = size; d_data_in = wd;
        end else begin
            i_req = 1'b1; i_address = addr; i_access_size = size;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (port ? d_gnt : i_gnt) begin
                got = 1;
                break;
            end
        end
        chk("grant_seen", {95'd0, got}, 96'd1);
        @(posedge clock); #1;
        if (port) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic wait_quiet;
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (!m_enable && !i_rvalid && !d_rvalid) begin
                ok = 1;
                break;
            end
        end
        chk("quiet_timeout", {95'd0, ok}, 96'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] burst_addr [5];
    logic        order [10];
    int          ng;

    initial begin
        reset_n = 1'b0;
        i_req = 1'b1; i_address = 32'h8002_0000; i_access_size = 2'b00;
        d_req = 1'b1; d_rw = 1'b1; d_address = 32'h8002_0200; d_access_size = 2'b00;
        d_data_in = 32'd0; m_busy = 1'b0;

        // Reset with both requests high
        repeat (3) begin
            @(negedge clock);
            chk("reset_ctl", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_enable, m_rw, m_access_size},
                8'b0000_0100);
            chk("reset_bus", {m_address, m_data_in, i_rdata | d_rdata}, 96'd0);
        end
        @(posedge clock); #1;
        push_exp(1'b1, 32'hA000_0080);
        reset_n = 1'b1;
        @(negedge clock);
        chk("first_grant", {i_gnt, d_gnt}, 2'b01);
        @(posedge clock); #1;
        i_req = 1'b0; d_req = 1'b0;
        wait_quiet();

        // Single fetch
        push_exp(1'b0, 32'h8FBE_0010);
        issue(1'b0, 1'b1, 32'h8002_0000, 2'b00, 32'd0);
        @(negedge clock);
        chk("single_beat", {m_enable, m_rw, m_address}, {2'b11, 32'h8002_0000});
        @(negedge clock);
        chk("single_rvalid", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'h8FBE_0010});
        wait_quiet();

        // Burst of 4 with one busy cycle on the second beat
        alog.delete();
        push_exp(1'b0, 32'h8FBE_0010);
        push_exp(1'b0, 32'hA000_0001);
        push_exp(1'b0, 32'hA000_0002);
        push_exp(1'b0, 32'hA000_0003);
        issue(1'b0, 1'b1, 32'h8002_0000, 2'b01, 32'd0);
        @(posedge clock); #1; m_busy = 1'b1;
        @(posedge clock); #1; m_busy = 1'b0;
        wait_quiet();
        burst_addr = '{32'h8002_0000, 32'h8002_0004, 32'h8002_0004, 32'h8002_0008, 32'h8002_000C};
        chk("burst_beats", alog.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < alog.size()) chk("burst_addr", alog[i][63:32], burst_addr[i]);

        // Priority with starvation limit of 4
        glog.delete();
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++)
            push_exp(order[i], order[i] ? 32'hA000_0020 : 32'hA000_0010);
        i_address = 32'h8002_0040; i_access_size = 2'b00;
        d_address = 32'h8002_0080; d_access_size = 2'b00; d_rw = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        ng = 0;
        for (int k = 0; k < 100 && ng < 10; k++) begin
            @(negedge clock);
            if (i_gnt || d_gnt) ng++;
        end
        @(posedge clock); #1;
        i_req = 1'b0; d_req = 1'b0;
        wait_quiet();
        chk("grant_count", glog.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < glog.size()) chk("grant_order", glog[i], order[i]);

        // Write then read back
        alog.delete();
        issue(1'b1, 1'b0, 32'h8002_0100, 2'b11, 32'hDEAD_BEEF);
        wait_quiet();
        chk("wr_beats", alog.size(), 1);
        if (alog.size() > 0) chk("wr_beat", alog[0], {1'b0, 32'h8002_0100, 32'hDEAD_BEEF});
        push_exp(1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 32'h8002_0100, 2'b00, 32'd0);
        wait_quiet();

        // Reset in the middle of a 16-beat fetch
        alog.delete();
        push_exp(1'b0, 32'h8FBE_0010);
        push_exp(1'b0, 32'hA000_0001);
        push_exp(1'b0, 32'hA000_0002);
        push_exp(1'b0, 32'hA000_0003);
        issue(1'b0, 1'b1, 32'h8002_0000, 2'b11, 32'd0);
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_outputs", {m_enable, i_rvalid, d_rvalid, m_rw, m_address}, {4'b0001, 32'd0});
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("midrst_idle", {m_enable, i_rvalid, d_rvalid, i_gnt, d_gnt}, 5'b0);
        end
        chk("midrst_beats", alog.size(), 5);
        @(posedge clock); #1;
        push_exp(1'b0, 32'h8FBE_0010);
        issue(1'b0, 1'b1, 32'h8002_0000, 2'b00, 32'd0);
        wait_quiet();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
